// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser: command table,
// ASCII control codes, receiver state encoding and small helpers.
package uart_cmd_pkg;

  localparam int unsigned N_CMD       = 8;
  localparam int unsigned CMD_W       = 3;
  localparam int unsigned CMD_MAX_LEN = 5;
  localparam int unsigned CMD_LEN_W   = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_LED   = 3'd0,
    CMD_RS    = 3'd1,
    CMD_RESET = 3'd2,
    CMD_CLEAR = 3'd3,
    CMD_SR    = 3'd4,
    CMD_DHT   = 3'd5,
    CMD_UP    = 3'd6,
    CMD_DOWN  = 3'd7
  } cmd_id_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_BS = 8'h08;

  // Strings are right-justified; entry N_CMD-1 is leftmost in the literal.
  localparam logic [N_CMD-1:0][8*CMD_MAX_LEN-1:0] CMD_STR = {
    40'("DOWN"), 40'("UP"), 40'("DHT"), 40'("SR"),
    40'("CLEAR"), 40'("RESET"), 40'("R/S"), 40'("LED")
  };

  localparam logic [N_CMD-1:0][CMD_LEN_W-1:0] CMD_LEN = {
    3'd4, 3'd2, 3'd3, 3'd2, 3'd5, 3'd5, 3'd3, 3'd3
  };

  // Character pos (0 = first typed) of table entry id; 0 beyond its length.
  function automatic logic [7:0] cmd_char(input int unsigned id, input int unsigned pos);
    int unsigned len;
    len = 32'(CMD_LEN[id]);
    if (pos < len) return CMD_STR[id][8*(len-1-pos) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] fold_char(input logic [7:0] c, input logic en);
    if (en && (c >= 8'h61) && (c <= 8'h7A)) return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Oversampled 8N1 receiver: rx synchroniser, tick divider and framing FSM.
// Delivers one byte strobe per good frame, or a frame-error strobe.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

  logic             r_rx_meta, r_rx_sync;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;

  rx_state_e        r_state, w_state_nxt;
  logic [OS_W-1:0]  r_os_cnt, w_os_nxt;
  logic [2:0]       r_bit_idx, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_byte_valid, w_valid_nxt;
  logic             r_frame_err, w_ferr_nxt;
  logic             r_busy, w_busy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Free-running oversample tick; the sample phase is set by r_os_cnt.
  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RX_IDLE;
      r_os_cnt     <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_os_cnt     <= w_os_nxt;
      r_bit_idx    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_valid_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt = RX_START;
          w_os_nxt    = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(OVERSAMPLE/2 - 1)) begin
            w_os_nxt = '0;
            if (r_rx_sync) begin
              w_state_nxt = RX_IDLE;
            end else begin
              w_state_nxt = RX_DATA;
              w_bit_nxt   = '0;
            end
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            w_os_nxt    = '0;
            w_shift_nxt = {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
            else                   w_bit_nxt   = r_bit_idx + 3'd1;
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            w_os_nxt = '0;
            if (r_rx_sync) begin
              w_valid_nxt = 1'b1;
              w_state_nxt = RX_IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = RX_WAIT_IDLE;
            end
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (r_rx_sync) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == RX_DATA) || (w_state_nxt == RX_STOP);
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = r_busy;

endmodule

// File: rtl/uart_cmd_parser.sv
// UART line receiver and ASCII command decoder: buffers one line, handles
// backspace and case folding, and strobes the matching command or an error.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned CASE_FOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_id,
  output logic [N_CMD-1:0] cmd_pulse,
  output logic             led,
  output logic             unknown_cmd,
  output logic             overflow_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  logic [7:0]       w_byte;
  logic             w_byte_valid;
  logic             w_is_term;
  logic [7:0]       r_buf [MAX_LEN];
  logic [LEN_W-1:0] r_len;
  logic             r_ovf;
  logic [N_CMD-1:0] w_match;
  logic [CMD_W-1:0] w_id;

  logic             r_cmd_valid, r_led, r_unknown, r_ovf_err;
  logic [CMD_W-1:0] r_cmd_id;
  logic [N_CMD-1:0] r_cmd_pulse;

  uart_rx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  assign w_is_term = (w_byte == ASCII_CR) || (w_byte == ASCII_LF);

  // Line buffer editing; a terminator on an empty line is ignored entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) r_buf[IDX_W'(i)] <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_is_term) begin
        if (r_len != '0) begin
          r_len <= '0;
          r_ovf <= 1'b0;
        end
      end else if (w_byte == ASCII_BS) begin
        if (r_len != '0) r_len <= r_len - LEN_W'(1);
      end else if (r_len < LEN_W'(MAX_LEN)) begin
        r_buf[IDX_W'(r_len)] <= fold_char(w_byte, CASE_FOLD != 0);
        r_len                <= r_len + LEN_W'(1);
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Exact match: length and every character; table entries are distinct.
  always_comb begin
    w_match = '0;
    w_id    = '0;
    for (int k = 0; k < N_CMD; k++) begin
      w_match[k] = (r_len == LEN_W'(CMD_LEN[k]));
      for (int i = 0; i < CMD_MAX_LEN; i++) begin
        if ((i < int'(CMD_LEN[k])) && (r_buf[IDX_W'(i)] != cmd_char(k, i)))
          w_match[k] = 1'b0;
      end
      if (w_match[k]) w_id = CMD_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= '0;
      r_cmd_pulse <= '0;
      r_led       <= 1'b0;
      r_unknown   <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= '0;
      r_cmd_pulse <= '0;
      r_unknown   <= 1'b0;
      r_ovf_err   <= 1'b0;
      if (w_byte_valid && w_is_term && (r_len != '0)) begin
        if (r_ovf) begin
          r_ovf_err <= 1'b1;
        end else if (|w_match) begin
          r_cmd_valid <= 1'b1;
          r_cmd_id    <= w_id;
          r_cmd_pulse <= w_match;
          if (w_id == CMD_LED) r_led <= ~r_led;
        end else begin
          r_unknown <= 1'b1;
        end
      end
    end
  end

  assign cmd_valid    = r_cmd_valid;
  assign cmd_id       = r_cmd_id;
  assign cmd_pulse    = r_cmd_pulse;
  assign led          = r_led;
  assign unknown_cmd  = r_unknown;
  assign overflow_err = r_ovf_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: folding and exact-match instances share one rx
// line; observed strobes are compared against a line-level reference model.
module tb_uart_cmd_parser;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned OS       = 8;
  localparam int unsigned MAX_LEN  = 8;
  localparam int BIT_CLK = 16;
  localparam int EV_UNK  = 8;
  localparam int EV_OVF  = 9;
  localparam int EV_FERR = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  logic       cv_a, led_a, unk_a, ovf_a, fe_a, busy_a;
  logic [2:0] id_a;
  logic [7:0] pul_a;
  logic       cv_b, led_b, unk_b, ovf_b, fe_b, busy_b;
  logic [2:0] id_b;
  logic [7:0] pul_b;

  always #5 clk = ~clk;

  uart_cmd_parser #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                    .MAX_LEN(MAX_LEN), .CASE_FOLD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx), .cmd_valid(cv_a), .cmd_id(id_a),
    .cmd_pulse(pul_a), .led(led_a), .unknown_cmd(unk_a), .overflow_err(ovf_a),
    .frame_err(fe_a), .busy(busy_a));

  uart_cmd_parser #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                    .MAX_LEN(MAX_LEN), .CASE_FOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx), .cmd_valid(cv_b), .cmd_id(id_b),
    .cmd_pulse(pul_b), .led(led_b), .unknown_cmd(unk_b), .overflow_err(ovf_b),
    .frame_err(fe_b), .busy(busy_b));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_ev_cyc = 0;
  int last_stop_cyc = 0;
  int pulse_err = 0;
  bit busy_seen = 1'b0;
  int obs_a[$], obs_b[$], exp_a[$], exp_b[$];

  string cmds[8] = '{"LED", "R/S", "RESET", "CLEAR", "SR", "DHT", "UP", "DOWN"};
  byte unsigned mbuf[2][MAX_LEN];
  int  mlen[2];
  bit  movf[2];
  bit  mled[2];

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cv_a) begin
      obs_a.push_back(int'(id_a));
      last_ev_cyc <= cyc;
      if (pul_a !== (8'(1) << id_a)) pulse_err <= pulse_err + 1;
    end else if (pul_a !== 8'h00) pulse_err <= pulse_err + 1;
    if (unk_a) begin obs_a.push_back(EV_UNK); last_ev_cyc <= cyc; end
    if (ovf_a) obs_a.push_back(EV_OVF);
    if (fe_a)  obs_a.push_back(EV_FERR);
    if (cv_b) begin
      obs_b.push_back(int'(id_b));
      if (pul_b !== (8'(1) << id_b)) pulse_err <= pulse_err + 1;
    end else if (pul_b !== 8'h00) pulse_err <= pulse_err + 1;
    if (unk_b) obs_b.push_back(EV_UNK);
    if (ovf_b) obs_b.push_back(EV_OVF);
    if (fe_b)  obs_b.push_back(EV_FERR);
    if (busy_a) busy_seen <= 1'b1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_eval(input int m);
    bit hit;
    if (movf[m]) return EV_OVF;
    for (int k = 0; k < 8; k++) begin
      if (cmds[k].len() == mlen[m]) begin
        hit = 1'b1;
        for (int i = 0; i < mlen[m]; i++)
          if (int'(mbuf[m][i]) != int'(cmds[k][i])) hit = 1'b0;
        if (hit) return k;
      end
    end
    return EV_UNK;
  endfunction

  // Line-level reference: model 0 folds case, model 1 matches exactly.
  task automatic model_byte(input byte unsigned b, input bit ok);
    int ev;
    byte unsigned c;
    for (int m = 0; m < 2; m++) begin
      ev = -1;
      if (!ok) ev = EV_FERR;
      else if (b == 8'h0D || b == 8'h0A) begin
        if (mlen[m] > 0) begin
          ev = model_eval(m);
          if (ev == 0) mled[m] = ~mled[m];
          mlen[m] = 0;
          movf[m] = 1'b0;
        end
      end else if (b == 8'h08) begin
        if (mlen[m] > 0) mlen[m]--;
      end else if (mlen[m] < MAX_LEN) begin
        c = b;
        if (m == 0 && c >= "a" && c <= "z") c = c - 8'd32;
        mbuf[m][mlen[m]] = c;
        mlen[m]++;
      end else movf[m] = 1'b1;
      if (ev >= 0) begin
        if (m == 0) exp_a.push_back(ev);
        else        exp_b.push_back(ev);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    last_stop_cyc = cyc;
    rx = ok;
    repeat (BIT_CLK) @(negedge clk);
    if (!ok) begin
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end
    model_byte(b, ok);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic check_events(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "/count_a"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++)
      chk({tag, "/ev_a"}, (i < obs_a.size()) ? obs_a[i] : -1, exp_a[i]);
    chk({tag, "/count_b"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      chk({tag, "/ev_b"}, (i < obs_b.size()) ? obs_b[i] : -1, exp_b[i]);
    chk({tag, "/led_a"}, int'(led_a), int'(mled[0]));
    chk({tag, "/led_b"}, int'(led_b), int'(mled[1]));
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mlen[m] = 0; movf[m] = 1'b0; mled[m] = 1'b0;
    end
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  initial begin
    int lat, sel, k, len, t;
    byte unsigned c;
    model_reset();

    // Reset state
    repeat (5) @(negedge clk);
    chk("reset_out_a", int'({cv_a, id_a, pul_a, led_a, unk_a, ovf_a, fe_a, busy_a}), 0);
    chk("reset_out_b", int'({cv_b, id_b, pul_b, led_b, unk_b, ovf_b, fe_b, busy_b}), 0);
    rst_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    // LED twice: led 0->1->0
    send_str("LED\r\n"); check_events("led1");
    send_str("LED\r\n"); check_events("led2");

    // Basic commands, latency from terminator stop bit
    busy_seen = 1'b0;
    send_str("R/S\r");
    chk("busy_seen", int'(busy_seen), 1);
    lat = last_ev_cyc - last_stop_cyc;
    chk("rs_latency_ok", int'(lat >= 2 && lat <= BIT_CLK), 1);
    send_str("\n"); check_events("rs");
    send_str("reset\r\n"); check_events("reset_lc");
    send_str("DOWN\n"); check_events("down");

    // Prefix, extension, blank lines
    send_str("RESETX\r\n"); check_events("resetx");
    send_str("RES\r\n"); check_events("res");
    send_str("\r\n\r\n"); check_events("blank");

    // Overflow then recovery
    send_str("ABCDEFGHIJ\r\n"); check_events("overflow");
    send_str("UP\r\n"); check_events("up");

    // Backspace editing
    send_str("SX"); send_byte(8'h08, 1'b1); send_str("R\r\n"); check_events("bs");
    send_byte(8'h08, 1'b1); send_str("UP\r\n"); check_events("bs_empty");

    // Start-bit glitch of two oversample ticks
    busy_seen = 1'b0;
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    chk("glitch_busy", int'(busy_seen), 0);
    check_events("glitch");

    // Frame error mid-line keeps the partial line
    send_str("DH"); send_byte("D", 1'b0); check_events("ferr");
    send_str("T\r\n"); check_events("dht");

    // Reset in the middle of a byte
    send_str("LED\r\n"); check_events("led3");
    send_str("CL");
    @(negedge clk); rx = 1'b0;
    repeat (5 * BIT_CLK) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_out_a", int'({cv_a, id_a, pul_a, led_a, unk_a, ovf_a, fe_a, busy_a}), 0);
    chk("midrst_out_b", int'({cv_b, id_b, pul_b, led_b, unk_b, ovf_b, fe_b, busy_b}), 0);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (BIT_CLK) @(negedge clk);
    send_str("CLEAR\r\n"); check_events("clear");

    // Randomized lines: table words in mixed case, edits, junk, overflow
    for (int n = 0; n < 15; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        k = int'($urandom_range(0, 7));
        for (int i = 0; i < cmds[k].len(); i++) begin
          c = cmds[k][i];
          if (c >= "A" && c <= "Z" && $urandom_range(0, 1) == 1) c = c + 8'd32;
          send_byte(c, 1'b1);
        end
        if (sel == 4) begin send_byte("Z", 1'b1); send_byte(8'h08, 1'b1); end
        if (sel == 5) send_byte("X", 1'b1);
      end else begin
        len = int'($urandom_range(1, 10));
        for (int i = 0; i < len; i++) send_byte(8'($urandom_range(8'h21, 8'h7E)), 1'b1);
      end
      t = int'($urandom_range(0, 2));
      if (t == 0)      send_byte(8'h0D, 1'b1);
      else if (t == 1) send_byte(8'h0A, 1'b1);
      else begin send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1); end
      check_events("rnd");
    end

    chk("pulse_consistency", pulse_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
